// File: rtl/matadd_scheduler_if.sv
// Handshake bundle between the matrix-add job scheduler, its two requesters
// and the datapath.
//   master : requesters + datapath side (drives requests, operands-ready, result strobe)
//   slave  : scheduler side (drives grants, takes, issue strobe/parity, results, status)
interface matadd_scheduler_if #(
    parameter int unsigned LEN_W = 4
);
    logic             enable;
    logic             req0;
    logic             req1;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic             src_rdy0;
    logic             src_rdy1;
    logic             grant0;
    logic             grant1;
    logic             take0;
    logic             take1;
    logic             dp_inReady;
    logic             dp_vectorSetInNo;
    logic             dp_outReady;
    logic             res_valid0;
    logic             res_valid1;
    logic             done0;
    logic             done1;
    logic             busy;
    logic             err;
    logic             timeout;

    modport master (
        output enable, req0, req1, len0, len1, src_rdy0, src_rdy1, dp_outReady,
        input  grant0, grant1, take0, take1, dp_inReady, dp_vectorSetInNo,
               res_valid0, res_valid1, done0, done1, busy, err, timeout
    );

    modport slave (
        input  enable, req0, req1, len0, len1, src_rdy0, src_rdy1, dp_outReady,
        output grant0, grant1, take0, take1, dp_inReady, dp_vectorSetInNo,
               res_valid0, res_valid1, done0, done1, busy, err, timeout
    );
endinterface

// File: rtl/matadd_scheduler.sv
// Two-requester job scheduler for a pipelined matrix-add datapath.
// A job of lenX vector sets is granted round-robin, its sets are issued while
// operands are ready and fewer than MAX_OUT sets are in flight, then the
// scheduler drains the datapath and pulses doneX.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : matadd_scheduler_if.slave (requests, grants, datapath strobes, status)
// Optional feature: define MATADD_SCHED_TIMEOUT_EN to add an 8-bit drain watchdog;
// without it timeout is tied to 0.
module matadd_scheduler #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input logic               clk,
    input logic               reset,
    matadd_scheduler_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    logic [1:0]       r_state, w_state_d;
    logic             r_owner;   // requester currently holding the datapath
    logic             r_prio;    // requester favoured at the next arbitration
    logic             r_grant0, r_grant1;
    logic             r_done0, r_done1;
    logic             r_parity;
    logic             r_err;
    logic [LEN_W-1:0] r_remain;
    logic [3:0]       r_out, w_out_d;

    logic             w_any_req, w_pick1, w_src_rdy, w_issue, w_ret, w_spur, w_wdog_fire;
    logic [LEN_W-1:0] w_len;

    assign w_any_req = bus.req0 | bus.req1;
    assign w_pick1   = bus.req1 & (~bus.req0 | r_prio);
    assign w_len     = w_pick1 ? bus.len1 : bus.len0;
    assign w_src_rdy = r_owner ? bus.src_rdy1 : bus.src_rdy0;

    assign w_issue = bus.enable && (r_state == ST_ISSUE) && w_src_rdy && (r_out < MAX_OUT_C);
    // A result with nothing in flight (e.g. left over from before a reset) is dropped.
    assign w_ret   = bus.enable && bus.dp_outReady && (r_out != 4'd0);
    assign w_spur  = bus.enable && bus.dp_outReady && (r_out == 4'd0);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_d = (w_len == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (w_issue && (r_remain == LEN_W'(1))) w_state_d = ST_DRAIN;
            ST_DRAIN: if ((r_out == 4'd0) || w_wdog_fire) w_state_d = ST_DONE;
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_out_d = r_out;
        if (w_wdog_fire)            w_out_d = 4'd0;
        else if (w_issue && !w_ret) w_out_d = r_out + 4'd1;
        else if (!w_issue && w_ret) w_out_d = r_out - 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_prio   <= 1'b0;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_parity <= 1'b0;
            r_err    <= 1'b0;
            r_remain <= '0;
            r_out    <= 4'd0;
        end else if (bus.enable) begin
            r_state <= w_state_d;
            r_out   <= w_out_d;
            r_err   <= r_err | w_spur;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_issue) begin
                r_remain <= r_remain - LEN_W'(1);
                r_parity <= ~r_parity;
            end
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_owner  <= w_pick1;
                r_grant0 <= ~w_pick1;
                r_grant1 <= w_pick1;
                r_prio   <= ~w_pick1;
                r_remain <= w_len;
            end
            if (r_state == ST_DONE) begin
                r_grant0 <= 1'b0;
                r_grant1 <= 1'b0;
                r_done0  <= ~r_owner;
                r_done1  <= r_owner;
            end
        end
    end

`ifdef MATADD_SCHED_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_timeout;

    assign w_wdog_fire = bus.enable && (r_state == ST_DRAIN) && !bus.dp_outReady &&
                         (r_wdog == 8'hFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog    <= 8'd0;
            r_timeout <= 1'b0;
        end else if (bus.enable) begin
            if ((r_state != ST_DRAIN) || bus.dp_outReady || w_wdog_fire) r_wdog <= 8'd0;
            else                                                          r_wdog <= r_wdog + 8'd1;
            if (w_wdog_fire) r_timeout <= 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_wdog_fire = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Parity shows the post-toggle value during an issue cycle, so the first set is 1.
    assign bus.dp_vectorSetInNo = r_parity ^ w_issue;
    assign bus.dp_inReady       = w_issue;
    assign bus.take0            = w_issue & ~r_owner;
    assign bus.take1            = w_issue & r_owner;
    assign bus.res_valid0       = w_ret & ~r_owner;
    assign bus.res_valid1       = w_ret & r_owner;
    assign bus.grant0           = r_grant0;
    assign bus.grant1           = r_grant1;
    assign bus.done0            = r_done0;
    assign bus.done1            = r_done1;
    assign bus.busy             = (r_state != ST_IDLE);
    assign bus.err              = r_err;
endmodule

// File: tb/tb_matadd_scheduler.sv
// Directed bench for matadd_scheduler. dut_a uses MAX_OUT=4, dut_b MAX_OUT=2.
// Each datapath is modelled as a shift register of issue strobes with a tap at
// latency-1. Cycle numbers below count negedges after the arbitration cycle (0).
module tb_matadd_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    matadd_scheduler_if #(.LEN_W(4)) bus_a ();
    matadd_scheduler_if #(.LEN_W(4)) bus_b ();

    matadd_scheduler #(.LEN_W(4), .MAX_OUT(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    matadd_scheduler #(.LEN_W(4), .MAX_OUT(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic [15:0] pipe_a = '0;
    logic [15:0] pipe_b = '0;
    logic [3:0]  tap_a = 4'd1;
    logic [3:0]  tap_b = 4'd5;
    logic        drop_a = 1'b0;
    logic        spur_a = 1'b0;

    always @(posedge clk) begin
        pipe_a <= {pipe_a[14:0], bus_a.dp_inReady & ~drop_a};
        pipe_b <= {pipe_b[14:0], bus_b.dp_inReady};
    end
    assign bus_a.dp_outReady = pipe_a[tap_a] | spur_a;
    assign bus_b.dp_outReady = pipe_b[tap_b];

    task automatic clear_inputs();
        bus_a.enable = 1'b1; bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        bus_a.len0 = 4'd0; bus_a.len1 = 4'd0; bus_a.src_rdy0 = 1'b0; bus_a.src_rdy1 = 1'b0;
        bus_b.enable = 1'b1; bus_b.req0 = 1'b0; bus_b.req1 = 1'b0;
        bus_b.len0 = 4'd0; bus_b.len1 = 4'd0; bus_b.src_rdy0 = 1'b0; bus_b.src_rdy1 = 1'b0;
        drop_a = 1'b0; spur_a = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        repeat (16) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] va, vb;
        repeat (3) @(negedge clk);
        va = {bus_a.grant0, bus_a.grant1, bus_a.take0, bus_a.take1, bus_a.dp_inReady,
              bus_a.dp_vectorSetInNo, bus_a.res_valid0, bus_a.res_valid1, bus_a.done0,
              bus_a.done1, bus_a.busy, bus_a.err, bus_a.timeout};
        vb = {bus_b.grant0, bus_b.grant1, bus_b.take0, bus_b.take1, bus_b.dp_inReady,
              bus_b.dp_vectorSetInNo, bus_b.res_valid0, bus_b.res_valid1, bus_b.done0,
              bus_b.done1, bus_b.busy, bus_b.err, bus_b.timeout};
        checks++; if (va !== 13'd0) begin failures++; $display("FAIL reset_outs_a got=%b exp=0", va); end
        checks++; if (vb !== 13'd0) begin failures++; $display("FAIL reset_outs_b got=%b exp=0", vb); end
    endtask

    task automatic test_enable();
        apply_reset();
        bus_a.enable = 1'b0; bus_a.req0 = 1'b1; bus_a.len0 = 4'd1; bus_a.src_rdy0 = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({bus_a.grant0, bus_a.busy} !== 2'b00) begin
            failures++; $display("FAIL enable_low_hold got=%b exp=00", {bus_a.grant0, bus_a.busy}); end
        bus_a.enable = 1'b1;
        @(negedge clk);
        checks++; if ({bus_a.grant0, bus_a.busy} !== 2'b11) begin
            failures++; $display("FAIL enable_high_grant got=%b exp=11", {bus_a.grant0, bus_a.busy}); end
    endtask

    task automatic test_single();
        int n_iss = 0, first_iss = -1, last_iss = -1, n_res = 0, n_done = 0, done_cyc = -1;
        int take_bad = 0;
        logic [2:0] par = 3'b000;
        logic g1 = 1'b0;
        tap_a = 4'd1;
        apply_reset();
        bus_a.req0 = 1'b1; bus_a.len0 = 4'd3; bus_a.src_rdy0 = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 1) g1 = bus_a.grant0;
            if (cyc == 2) bus_a.len0 = 4'd9;  // must be ignored after grant
            if (bus_a.take0 !== bus_a.dp_inReady || bus_a.take1 !== 1'b0) take_bad++;
            if (bus_a.dp_inReady === 1'b1) begin
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
                if (n_iss < 3) par[2-n_iss] = bus_a.dp_vectorSetInNo;
                n_iss++;
            end
            if (bus_a.res_valid0 === 1'b1) n_res++;
            if (bus_a.done0 === 1'b1) begin n_done++; done_cyc = cyc; bus_a.req0 = 1'b0; end
        end
        checks++; if (g1 !== 1'b1) begin failures++; $display("FAIL single_grant got=%b exp=1", g1); end
        checks++; if (n_iss != 3) begin failures++; $display("FAIL single_n_issue got=%0d exp=3", n_iss); end
        checks++; if (first_iss != 1 || last_iss != 3) begin failures++;
            $display("FAIL single_issue_cycles got=%0d..%0d exp=1..3", first_iss, last_iss); end
        checks++; if (par !== 3'b101) begin failures++; $display("FAIL single_parity got=%b exp=101", par); end
        checks++; if (n_res != 3) begin failures++; $display("FAIL single_res_valid got=%0d exp=3", n_res); end
        checks++; if (n_done != 1 || done_cyc != 8) begin failures++;
            $display("FAIL single_done got=%0d@%0d exp=1@8", n_done, done_cyc); end
        checks++; if (take_bad != 0) begin failures++; $display("FAIL single_take got=%0d exp=0", take_bad); end
        checks++; if ({bus_a.busy, bus_a.err, bus_a.grant0} !== 3'b000) begin failures++;
            $display("FAIL single_end_state got=%b exp=000", {bus_a.busy, bus_a.err, bus_a.grant0}); end
    endtask

    task automatic test_round_robin();
        int n_iss = 0, done0_cyc = -1, done1_cyc = -1, both = 0, regrant_cyc = -1;
        logic first_g0 = 1'b0;
        logic [1:0] regrant = 2'b00;
        bit rereq = 0;
        tap_a = 4'd1;
        apply_reset();
        bus_a.req0 = 1'b1; bus_a.req1 = 1'b1; bus_a.len0 = 4'd2; bus_a.len1 = 4'd2;
        bus_a.src_rdy0 = 1'b1; bus_a.src_rdy1 = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) first_g0 = bus_a.grant0;
            if (bus_a.grant0 === 1'b1 && bus_a.grant1 === 1'b1) both++;
            if (bus_a.dp_inReady === 1'b1) n_iss++;
            if (rereq && regrant_cyc < 0 && (bus_a.grant0 | bus_a.grant1) === 1'b1) begin
                regrant = {bus_a.grant1, bus_a.grant0}; regrant_cyc = cyc;
            end
            if (bus_a.done0 === 1'b1 && done0_cyc < 0) begin done0_cyc = cyc; bus_a.req0 = 1'b0; end
            if (bus_a.done1 === 1'b1 && done1_cyc < 0) begin done1_cyc = cyc; bus_a.req1 = 1'b0; end
            if (!rereq && done0_cyc > 0 && done1_cyc > 0) begin
                rereq = 1; bus_a.req0 = 1'b1; bus_a.req1 = 1'b1; bus_a.len0 = 4'd1; bus_a.len1 = 4'd1;
            end
        end
        checks++; if (first_g0 !== 1'b1) begin failures++; $display("FAIL rr_first_grant0 got=%b exp=1", first_g0); end
        checks++; if (done0_cyc != 7 || done1_cyc != 14) begin failures++;
            $display("FAIL rr_done_order got=%0d,%0d exp=7,14", done0_cyc, done1_cyc); end
        checks++; if (regrant !== 2'b01 || regrant_cyc != 15) begin failures++;
            $display("FAIL rr_regrant got=%b@%0d exp=01@15", regrant, regrant_cyc); end
        checks++; if (both != 0) begin failures++; $display("FAIL rr_dual_grant got=%0d exp=0", both); end
        checks++; if (n_iss < 4) begin failures++; $display("FAIL rr_issues got=%0d exp>=4", n_iss); end
    endtask

    task automatic test_max_out();
        int iss = 0, ret = 0, over = 0, max_o = 0, stall = 0, last_iss = -1, done_cyc = -1;
        tap_b = 4'd5;
        apply_reset();
        bus_b.req0 = 1'b1; bus_b.len0 = 4'd5; bus_b.src_rdy0 = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus_b.dp_inReady === 1'b1 && (iss - ret) >= 2) over++;
            if (bus_b.grant0 === 1'b1 && bus_b.dp_inReady === 1'b0 && iss < 5) stall++;
            if (bus_b.dp_inReady === 1'b1) begin iss++; last_iss = cyc; end
            if (bus_b.res_valid0 === 1'b1) ret++;
            if ((iss - ret) > max_o) max_o = iss - ret;
            if (bus_b.done0 === 1'b1) begin done_cyc = cyc; bus_b.req0 = 1'b0; end
        end
        checks++; if (iss != 5 || ret != 5) begin failures++;
            $display("FAIL maxout_counts got=%0d/%0d exp=5/5", iss, ret); end
        checks++; if (over != 0 || max_o != 2) begin failures++;
            $display("FAIL maxout_limit got=over%0d,max%0d exp=over0,max2", over, max_o); end
        checks++; if (stall != 10 || last_iss != 15) begin failures++;
            $display("FAIL maxout_stall got=%0d,last%0d exp=10,last15", stall, last_iss); end
        checks++; if (done_cyc != 24) begin failures++; $display("FAIL maxout_done got=%0d exp=24", done_cyc); end
    endtask

    task automatic test_zero_len();
        int g_cyc = -1, d_cyc = -1, n_iss = 0;
        tap_a = 4'd1;
        apply_reset();
        bus_a.req1 = 1'b1; bus_a.len1 = 4'd0; bus_a.len0 = 4'd3; bus_a.src_rdy1 = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (bus_a.grant1 === 1'b1 && g_cyc < 0) g_cyc = cyc;
            if (bus_a.dp_inReady === 1'b1) n_iss++;
            if (bus_a.done1 === 1'b1) begin d_cyc = cyc; bus_a.req1 = 1'b0; end
        end
        checks++; if (g_cyc != 1 || d_cyc != 2) begin failures++;
            $display("FAIL zero_len_timing got=g%0d,d%0d exp=g1,d2", g_cyc, d_cyc); end
        checks++; if (n_iss != 0) begin failures++; $display("FAIL zero_len_issue got=%0d exp=0", n_iss); end
    endtask

    task automatic test_spurious_reset();
        int n_iss = 0, d_cyc = -1, rv = 0;
        logic [12:0] va;
        tap_a = 4'd1;
        apply_reset();
        spur_a = 1'b1;
        #1;
        checks++; if ({bus_a.res_valid0, bus_a.res_valid1} !== 2'b00) begin failures++;
            $display("FAIL spur_res_valid got=%b exp=00", {bus_a.res_valid0, bus_a.res_valid1}); end
        @(negedge clk);
        spur_a = 1'b0;
        checks++; if ({bus_a.err, bus_a.busy} !== 2'b10) begin failures++;
            $display("FAIL spur_err got=%b exp=10", {bus_a.err, bus_a.busy}); end
        // Outstanding must still be 0: a one-set job then runs with normal timing.
        bus_a.req0 = 1'b1; bus_a.len0 = 4'd1; bus_a.src_rdy0 = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (bus_a.dp_inReady === 1'b1) n_iss++;
            if (bus_a.done0 === 1'b1) begin d_cyc = cyc; bus_a.req0 = 1'b0; end
        end
        checks++; if (n_iss != 1 || d_cyc != 6 || bus_a.err !== 1'b1) begin failures++;
            $display("FAIL spur_followup got=i%0d,d%0d,e%b exp=i1,d6,e1", n_iss, d_cyc, bus_a.err); end
        // Reset in the middle of ISSUE.
        bus_a.req0 = 1'b1; bus_a.len0 = 4'd5; bus_a.src_rdy0 = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({bus_a.dp_inReady, bus_a.busy} !== 2'b11) begin failures++;
            $display("FAIL midreset_pre got=%b exp=11", {bus_a.dp_inReady, bus_a.busy}); end
        #2;
        reset = 1'b0; bus_a.req0 = 1'b0; bus_a.src_rdy0 = 1'b0;
        #1;
        va = {bus_a.grant0, bus_a.grant1, bus_a.take0, bus_a.take1, bus_a.dp_inReady,
              bus_a.dp_vectorSetInNo, bus_a.res_valid0, bus_a.res_valid1, bus_a.done0,
              bus_a.done1, bus_a.busy, bus_a.err, bus_a.timeout};
        checks++; if (va !== 13'd0) begin failures++; $display("FAIL midreset_outs got=%b exp=0", va); end
        reset = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if ((bus_a.res_valid0 | bus_a.res_valid1) === 1'b1) rv++;
        end
        checks++; if (bus_a.err !== 1'b1 || rv != 0 || bus_a.busy !== 1'b0) begin failures++;
            $display("FAIL stale_result got=e%b,rv%0d,b%b exp=e1,rv0,b0", bus_a.err, rv, bus_a.busy); end
    endtask

    task automatic test_timeout();
        int n_iss = 0, n_res = 0, to_cyc = -1, d_cyc = -1;
        tap_a = 4'd1;
        apply_reset();
        bus_a.req0 = 1'b1; bus_a.len0 = 4'd2; bus_a.src_rdy0 = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            drop_a = 1'b0;
            if (bus_a.dp_inReady === 1'b1) begin
                n_iss++;
                if (n_iss == 2) drop_a = 1'b1;  // withhold the second result
            end
            if (bus_a.res_valid0 === 1'b1) n_res++;
            if (bus_a.timeout === 1'b1 && to_cyc < 0) to_cyc = cyc;
            if (bus_a.done0 === 1'b1) begin d_cyc = cyc; bus_a.req0 = 1'b0; end
        end
        checks++; if (n_iss != 2 || n_res != 1) begin failures++;
            $display("FAIL wdog_traffic got=%0d/%0d exp=2/1", n_iss, n_res); end
`ifdef MATADD_SCHED_TIMEOUT_EN
        checks++; if (to_cyc != 260 || d_cyc != 261) begin failures++;
            $display("FAIL wdog_fire got=t%0d,d%0d exp=t260,d261", to_cyc, d_cyc); end
        checks++; if ({bus_a.timeout, bus_a.busy, bus_a.err} !== 3'b100) begin failures++;
            $display("FAIL wdog_after got=%b exp=100", {bus_a.timeout, bus_a.busy, bus_a.err}); end
`else
        checks++; if (to_cyc != -1 || d_cyc != -1) begin failures++;
            $display("FAIL no_wdog got=t%0d,d%0d exp=t-1,d-1", to_cyc, d_cyc); end
        checks++; if ({bus_a.timeout, bus_a.busy} !== 2'b01) begin failures++;
            $display("FAIL no_wdog_state got=%b exp=01", {bus_a.timeout, bus_a.busy}); end
`endif
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_enable();
        test_single();
        test_round_robin();
        test_max_out();
        test_zero_len();
        test_spurious_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
